mmio_arbiter: RTL and testbench

Two-master arbiter that shares the single MMIO port of `mmio_xbar` (hex display and future peripherals) between the CPU and a second requester, such as a debug loader or DMA engine. Each cycle it grants at most one master using round-robin priority and drives that master's access onto the crossbar. It registers the read data back to the winning master one cycle later. Optional bus locking lets one master perform back-to-back accesses without interleaving.

---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_arbiter_if.sv | 20 ++
 rtl/mmio_arbiter_rr_arb2.sv | 21 ++
 rtl/mmio_arbiter.sv | 140 ++++++++++++++
 tb/tb_mmio_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO constants: default bus widths, master indices and lock FSM states.
package mmio_pkg;
    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;
    localparam int MST_CPU    = 0;
    localparam int MST_AUX    = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    function automatic logic [1:0] idx2oh(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mmio_arbiter_if.sv
// Per-master MMIO request/response bundle; the arbiter sees each master through the slave modport.
interface mmio_arbiter_if
    import mmio_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  req;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   mask;
    logic                  wren;
    logic                  lock;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, addr, data, mask, wren, lock, input gnt, rvalid, rdata);
    modport slave  (input req, addr, data, mask, wren, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-input round-robin picker; force_i restricts the grant to owner_i (bus lock).
module rr_arb2
    import mmio_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       force_i,
    input  logic       owner_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = '0;
        if (force_i) begin
            if (req_i[owner_i]) gnt_o = idx2oh(owner_i);
        end else if (&req_i) begin
            gnt_o = idx2oh(~last_i);
        end else begin
            gnt_o = req_i;
        end
    end
endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter onto the single MMIO crossbar port, 1-cycle registered read data.
// Optional bus locking enabled by defining MMIO_ARB_LOCK_EN.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    mmio_arbiter_if.slave       m0,
    mmio_arbiter_if.slave       m1,
    output logic [ADDR_W-1:0]   o_mmio_addr,
    output logic [DATA_W-1:0]   o_mmio_data,
    output logic [DATA_W/8-1:0] o_mmio_mask,
    output logic                o_mmio_wren,
    input  logic [DATA_W-1:0]   i_mmio_data
);
    logic [1:0]             req, gnt, rd_en;
    logic                   win, any, owner, force_en;
    logic                   last_q, last_d;
    logic [1:0]             rvalid_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    // Masking with rst keeps grants and the crossbar port quiet during reset.
    assign req = {m1.req, m0.req} & {2{~rst}};

    rr_arb2 u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .force_i (force_en),
        .owner_i (owner),
        .gnt_o   (gnt)
    );

    assign m0.gnt = gnt[MST_CPU];
    assign m1.gnt = gnt[MST_AUX];
    assign win    = gnt[MST_AUX];
    assign any    = |gnt;
    assign rd_en  = gnt & ~{m1.wren, m0.wren};

    always_comb begin
        o_mmio_addr = '0;
        o_mmio_data = '0;
        o_mmio_mask = '0;
        o_mmio_wren = 1'b0;
        if (gnt[MST_CPU]) begin
            o_mmio_addr = m0.addr;
            o_mmio_data = m0.data;
            o_mmio_mask = m0.mask;
            o_mmio_wren = m0.wren;
        end else if (gnt[MST_AUX]) begin
            o_mmio_addr = m1.addr;
            o_mmio_data = m1.data;
            o_mmio_mask = m1.mask;
            o_mmio_wren = m1.wren;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            last_q   <= last_d;
            rvalid_q <= rd_en;
            for (int i = 0; i < 2; i++)
                if (rd_en[i]) rdata_q[i] <= i_mmio_data;
        end
    end

    assign m0.rvalid = rvalid_q[MST_CPU];
    assign m1.rvalid = rvalid_q[MST_AUX];
    assign m0.rdata  = rdata_q[MST_CPU];
    assign m1.rdata  = rdata_q[MST_AUX];

`ifdef MMIO_ARB_LOCK_EN
    localparam int CNT_W = ($clog2(LOCK_MAX) > 0) ? $clog2(LOCK_MAX) : 1;

    lock_state_e      state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_w;

    assign lock_w   = win ? m1.lock : m0.lock;
    assign force_en = (state_q == ST_LOCKED);
    assign owner    = owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = any ? win : last_q;
        case (state_q)
            ST_IDLE: begin
                if (any && lock_w) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout hands priority to the stalled master.
                if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (any && !lock_w) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    localparam int unused_lock_max = LOCK_MAX;
    logic unused_lock;

    assign unused_lock = m0.lock ^ m1.lock;
    assign force_en    = 1'b0;
    assign owner       = 1'b0;
    assign last_d      = any ? win : last_q;
`endif
endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench: driver pushes reference-model expectations, negedge monitor pops and compares.
module tb_mmio_arbiter;
    import mmio_pkg::*;
    localparam int AW = ADDR_W_DEF, DW = DATA_W_DEF, MW = DW / 8, LMAX = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data, i_data;
    logic [MW-1:0] o_mask;
    logic          o_wren;

    logic [1:0]    req, wren, lock;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] data [2];
    logic [MW-1:0] mask [2];

    mmio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    mmio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    assign m0_if.req = req[0];  assign m1_if.req = req[1];
    assign m0_if.addr = addr[0]; assign m1_if.addr = addr[1];
    assign m0_if.data = data[0]; assign m1_if.data = data[1];
    assign m0_if.mask = mask[0]; assign m1_if.mask = mask[1];
    assign m0_if.wren = wren[0]; assign m1_if.wren = wren[1];
    assign m0_if.lock = lock[0]; assign m1_if.lock = lock[1];

    mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .o_mmio_addr (o_addr),
        .o_mmio_data (o_data),
        .o_mmio_mask (o_mask),
        .o_mmio_wren (o_wren),
        .i_mmio_data (i_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    gnt;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic          wren;
        logic [1:0]    rv;
        logic [DW-1:0] rd0, rd1;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_bad = 0;

    // Reference model state, expressed as the architectural values a master would observe.
    int            last = 1;
    logic [1:0]    rv_m = '0;
    logic [DW-1:0] rd_m [2] = '{default: '0};
    bit            locked = 0;
    int            owner = 0, lcnt = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt",    64'({m1_if.gnt, m0_if.gnt}), 64'(e.gnt));
            chk("addr",   64'(o_addr), 64'(e.addr));
            chk("data",   64'(o_data), 64'(e.data));
            chk("mask",   64'(o_mask), 64'(e.mask));
            chk("wren",   64'(o_wren), 64'(e.wren));
            chk("rvalid", 64'({m1_if.rvalid, m0_if.rvalid}), 64'(e.rv));
            chk("rdata0", 64'(m0_if.rdata), 64'(e.rd0));
            chk("rdata1", 64'(m1_if.rdata), 64'(e.rd1));
        end
    end

    function automatic int pick();
        if (rst) return -1;
        if (locked) return req[owner] ? owner : -1;
        if (req[0] && req[1]) return 1 - last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    // Called once per cycle after inputs settle: queue expectation, then advance the model.
    task automatic step();
        exp_t e;
        int   w;
        if (rst) begin
            last = 1; rv_m = '0; rd_m = '{default: '0}; locked = 0; lcnt = 0;
        end
        w = pick();
        e.gnt  = (w < 0) ? 2'b00 : 2'(1 << w);
        e.addr = (w < 0) ? '0 : addr[w];
        e.data = (w < 0) ? '0 : data[w];
        e.mask = (w < 0) ? '0 : mask[w];
        e.wren = (w < 0) ? 1'b0 : wren[w];
        e.rv   = rv_m;
        e.rd0  = rd_m[0];
        e.rd1  = rd_m[1];
        sb.push_back(e);
        rv_m = '0;
        if (!rst) begin
            if (w >= 0) begin
                if (!wren[w]) begin
                    rv_m[w] = 1'b1;
                    rd_m[w] = i_data;
                end
                last = w;
            end
`ifdef MMIO_ARB_LOCK_EN
            if (locked) begin
                if (lcnt == LMAX - 1) begin
                    locked = 0; last = owner;
                end else if (w >= 0 && !lock[w]) begin
                    locked = 0;
                end
                lcnt++;
            end else if (w >= 0 && lock[w]) begin
                locked = 1; owner = w; lcnt = 0;
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; wren = '0; lock = '0;
        addr = '{default: '0}; data = '{default: '0}; mask = '{default: '0};
        i_data = '0;
    endtask

    task automatic both_read(input logic [DW-1:0] xd);
        req = 2'b11; wren = 2'b00; lock = '0;
        addr[0] = AW'($urandom); addr[1] = AW'($urandom);
        data[0] = $urandom; data[1] = $urandom;
        mask = '{MW'('1), MW'('1)};
        i_data = xd;
    endtask

    initial begin
        idle();
        tick(); step();                       // reset state
        tick(); rst = 1'b0; idle();           // m0-only write
        req[0] = 1'b1; addr[0] = '0; data[0] = 32'h1234; mask[0] = 4'hF; wren[0] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin     // continuous contention alternates
            tick(); both_read($urandom); step();
        end
        tick(); idle();                       // m1 read of 0xDEADBEEF
        req[1] = 1'b1; addr[1] = AW'(32'h40); i_data = 32'hDEADBEEF;
        step();
        tick(); idle(); step();
        tick(); both_read(32'hCAFEF00D); step();   // read, then reset mid-operation
        tick(); rst = 1'b1; both_read($urandom); step();
        tick(); rst = 1'b0; both_read($urandom); step();
        tick(); both_read($urandom); step();
`ifdef MMIO_ARB_LOCK_EN
        for (int i = 0; i < 24; i++) begin
            tick(); both_read($urandom); lock[0] = 1'b1; step();
        end
`endif
        for (int i = 0; i < 400; i++) begin
            tick(); idle();
            rst = ($urandom_range(0, 63) == 0);
            req = 2'($urandom); wren = 2'($urandom);
            lock = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            for (int m = 0; m < 2; m++) begin
                addr[m] = AW'($urandom); data[m] = $urandom; mask[m] = MW'($urandom);
            end
            i_data = $urandom;
            step();
        end
        tick(); rst = 1'b0; idle(); step();
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
